// File: rtl/axi_perf_pkg.sv
// axi_perf_pkg: counter bus published by the upstream AXI performance counters
package axi_perf_pkg;
  typedef struct packed {
    logic [63:0] r_bw;
    logic [63:0] w_bw;
    logic [63:0] busy_cnt;
  } perf_t;
endpackage

// File: rtl/axi_perf_sampler_pkg.sv
// axi_perf_sampler_pkg: types, register indices and helpers for axi_perf_sampler
// sample_t carries busy_delta only when AXI_PERF_SAMPLER_BUSY_EN is defined.
package axi_perf_sampler_pkg;
  localparam logic [2:0] CTRL   = 3'd0;
  localparam logic [2:0] WINDOW = 3'd1;
  localparam logic [2:0] THRESH = 3'd2;
  localparam logic [2:0] STATUS = 3'd3;
  localparam logic [2:0] SAMPLE = 3'd4;
  localparam logic [2:0] AUX    = 3'd5;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        valid;
  } reg_req_default_t;
  typedef struct packed {
    logic [63:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_default_t;
  typedef struct packed {
`ifdef AXI_PERF_SAMPLER_BUSY_EN
    logic [31:0] busy_delta;
`endif
    logic [31:0] w_delta;
    logic [31:0] r_delta;
  } sample_t;
  typedef struct packed {
    logic irq_en;
    logic clr;
    logic en;
  } ctrl_t;
  typedef struct packed {
    logic       thr;
    logic       ovf;
    logic [8:0] fill;
  } status_t;
  function automatic logic [31:0] sat32(input logic [63:0] d);
    return |d[63:32] ? 32'hFFFF_FFFF : d[31:0];
  endfunction
endpackage

// File: rtl/axi_perf_sampler_fifo.sv
// axi_perf_sampler_fifo: sample FIFO; flush beats push/pop, caller pushes only when a slot is free or being popped
module axi_perf_sampler_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type dtype = logic
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  dtype       data_i,
  output dtype       data_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [8:0] usage_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  dtype mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  assign data_o  = mem_q[rd_q];
  assign empty_o = usage_o == '0;
  assign full_o  = usage_o == 9'(DEPTH);
  // storage, pointers and fill level
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      usage_o <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      usage_o <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) rd_q <= rd_q + AW'(1);
      usage_o <= usage_o + 9'(push_i) - 9'(pop_i);
    end
endmodule

// File: rtl/axi_perf_sampler.sv
// axi_perf_sampler: per-window r/w byte deltas into a REGBUS-drained FIFO with threshold irq
// Define AXI_PERF_SAMPLER_BUSY_EN to also capture busy-cycle deltas, readable at AUX.
module axi_perf_sampler
  import axi_perf_sampler_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WIN_WIDTH = 32,
  parameter type reg_req_t = reg_req_default_t,
  parameter type reg_rsp_t = reg_rsp_default_t
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  reg_req_t            reg_req_i,
  output reg_rsp_t            reg_rsp_o,
  input  axi_perf_pkg::perf_t perf_i,
  output logic                irq_o
);
  logic [2:0] idx;
  logic wr, rd, wr_ctrl, clr, restart, win_end, push, pop, accept;
  logic full, empty, ovf_set, thr_set, ovf_n, thr_n, irq_en_n, ovf_q, thr_q;
  logic [1:0] w1c;
  logic [32:0] sum;
  logic [63:0] thresh_q, base_r_q, base_w_q, aux;
  logic [WIN_WIDTH-1:0] window_q, cnt_q;
  logic [8:0] fill;
  ctrl_t ctrl_q, ctrl_w;
  status_t status;
  sample_t smp, head;
  logic unused_bits;
  assign idx     = reg_req_i.addr[5:3];
  assign wr      = reg_req_i.valid & reg_req_i.write;
  assign rd      = reg_req_i.valid & ~reg_req_i.write;
  assign wr_ctrl = wr & (idx == CTRL);
  assign ctrl_w  = ctrl_t'(reg_req_i.wdata[2:0]);
  assign clr     = wr_ctrl & ctrl_w.clr;
  assign restart = clr | (wr & (idx == WINDOW)) | (wr_ctrl & ctrl_w.en & ~ctrl_q.en);
  assign win_end = ctrl_q.en & (window_q != '0) & (cnt_q == window_q - WIN_WIDTH'(1));
  assign push    = win_end & ~restart;
  assign pop     = rd & (idx == SAMPLE) & ~empty;
  assign accept  = push & (~full | pop);
  assign ovf_set = push & full & ~pop;
  assign smp.r_delta = sat32(perf_i.r_bw - base_r_q);
  assign smp.w_delta = sat32(perf_i.w_bw - base_w_q);
  assign sum      = {1'b0, smp.r_delta} + {1'b0, smp.w_delta};
  assign thr_set  = accept & (64'(sum) > thresh_q);
  assign w1c      = wr & (idx == STATUS) ? reg_req_i.wdata[10:9] : 2'b00;
  assign ovf_n    = ~clr & (ovf_set | (ovf_q & ~w1c[0]));
  assign thr_n    = ~clr & (thr_set | (thr_q & ~w1c[1]));
  assign irq_en_n = wr_ctrl ? ctrl_w.irq_en : ctrl_q.irq_en;
  assign status   = '{thr: thr_q, ovf: ovf_q, fill: fill};
`ifdef AXI_PERF_SAMPLER_BUSY_EN
  logic [63:0] base_b_q;
  assign smp.busy_delta = sat32(perf_i.busy_cnt - base_b_q);
  assign aux = empty ? '0 : {32'h0, head.busy_delta};
  assign unused_bits = ^{reg_req_i.addr[31:6], reg_req_i.addr[2:0], reg_req_i.wstrb};
  // busy base follows the byte bases
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) base_b_q <= '0;
    else if (restart | win_end) base_b_q <= perf_i.busy_cnt;
`else
  assign aux = '0;
  assign unused_bits = ^{reg_req_i.addr[31:6], reg_req_i.addr[2:0], reg_req_i.wstrb, perf_i.busy_cnt};
`endif
  axi_perf_sampler_fifo #(.DEPTH(DEPTH), .dtype(sample_t)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clr),
    .push_i  (accept),
    .pop_i   (pop),
    .data_i  (smp),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .usage_o (fill)
  );
  // registers, window counter, bases and the registered interrupt level
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      ctrl_q   <= '0;
      window_q <= '0;
      thresh_q <= '0;
      cnt_q    <= '0;
      base_r_q <= '0;
      base_w_q <= '0;
      ovf_q    <= 1'b0;
      thr_q    <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= '{irq_en: ctrl_w.irq_en, clr: 1'b0, en: ctrl_w.en};
      if (wr & (idx == WINDOW)) window_q <= reg_req_i.wdata[WIN_WIDTH-1:0];
      if (wr & (idx == THRESH)) thresh_q <= reg_req_i.wdata;
      cnt_q <= restart | win_end ? '0 : ctrl_q.en && window_q != '0 ? cnt_q + WIN_WIDTH'(1) : cnt_q;
      if (restart | win_end) begin
        base_r_q <= perf_i.r_bw;
        base_w_q <= perf_i.w_bw;
      end
      ovf_q <= ovf_n;
      thr_q <= thr_n;
      irq_o <= irq_en_n & thr_n;
    end
  // combinational REGBUS response
  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = 1'b1;
    reg_rsp_o.error = idx > AUX;
    reg_rsp_o.rdata = idx == CTRL   ? 64'(ctrl_q)
                    : idx == WINDOW ? 64'(window_q)
                    : idx == THRESH ? thresh_q
                    : idx == STATUS ? 64'(status)
                    : idx == SAMPLE ? (empty ? 64'd0 : {head.w_delta, head.r_delta})
                    : idx == AUX    ? aux
                    : 64'd0;
  end
endmodule
